// File: rtl/div_q16.sv
// Sequential signed Q16.16 divider: restoring radix-2 division on magnitudes,
// followed by sign application and saturation. Fixed 50-cycle initiation interval.
module div_q16 #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] val,
    output logic             div_zero,
    output logic             ovf
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        if (x[WIDTH-1]) begin
            m = ~x + ONE;
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_dvd;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic             r_asign;
    logic             r_zflag;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_val;
    logic             r_div_zero;
    logic             r_ovf;

    logic             w_load;
    logic             w_iter;
    logic             w_fix;
    logic             w_last;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic             w_q_hi;
    logic             w_ovf_pos;
    logic             w_ovf_neg;
    logic [WIDTH-1:0] w_neg_q;

    // Remainder shift/subtract and saturation detection on the finished quotient.
    assign w_rem_sh  = {r_rem[WIDTH-1:0], r_dvd[N-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_dvsr};
    assign w_ge      = ~w_diff[WIDTH+1];
    assign w_last    = (r_cnt == CW'(N - 1));
    assign w_q_hi    = |r_dvd[N-1:WIDTH];
    assign w_ovf_pos = ~r_sign & (w_q_hi | r_dvd[WIDTH-1]);
    assign w_ovf_neg = r_sign & (w_q_hi | (r_dvd[WIDTH-1] & (|r_dvd[WIDTH-2:0])));
    assign w_neg_q   = ~r_dvd[WIDTH-1:0] + ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_DIV;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_DIV;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control decode from the current state.
    always_comb begin
        w_load = 1'b0;
        w_iter = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            S_IDLE:  w_load = in_valid;
            S_DIV:   w_iter = 1'b1;
            S_FIX:   w_fix  = 1'b1;
            default: w_load = 1'b0;
        endcase
    end

    // Datapath: operand capture and one restoring step per DIV cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd   <= {N{1'b0}};
            r_dvsr  <= {WIDTH{1'b0}};
            r_rem   <= {(WIDTH+1){1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_sign  <= 1'b0;
            r_asign <= 1'b0;
            r_zflag <= 1'b0;
        end else if (w_load) begin
            r_dvd   <= {mag(a), {FRAC{1'b0}}};
            r_dvsr  <= mag(b);
            r_rem   <= {(WIDTH+1){1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            r_asign <= a[WIDTH-1];
            r_zflag <= (b == {WIDTH{1'b0}});
        end else if (w_iter) begin
            // Quotient bits fill the dividend register from the bottom as it drains.
            r_dvd <= {r_dvd[N-2:0], w_ge};
            if (w_ge) begin
                r_rem <= w_diff[WIDTH:0];
            end else begin
                r_rem <= w_rem_sh;
            end
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_dvd <= r_dvd;
        end
    end

    // Registered outputs; result fields update only in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_val       <= {WIDTH{1'b0}};
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= w_fix;
            if (w_load) begin
                r_in_ready <= 1'b0;
            end else if (w_fix) begin
                r_in_ready <= 1'b1;
            end else begin
                r_in_ready <= r_in_ready;
            end
            if (w_fix) begin
                if (r_zflag) begin
                    r_val      <= r_asign ? MIN_NEG : MAX_POS;
                    r_div_zero <= 1'b1;
                    r_ovf      <= 1'b0;
                end else if (w_ovf_pos) begin
                    r_val      <= MAX_POS;
                    r_div_zero <= 1'b0;
                    r_ovf      <= 1'b1;
                end else if (w_ovf_neg) begin
                    r_val      <= MIN_NEG;
                    r_div_zero <= 1'b0;
                    r_ovf      <= 1'b1;
                end else begin
                    r_val      <= r_sign ? w_neg_q : r_dvd[WIDTH-1:0];
                    r_div_zero <= 1'b0;
                    r_ovf      <= 1'b0;
                end
            end else begin
                r_val <= r_val;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign val       = r_val;
    assign div_zero  = r_div_zero;
    assign ovf       = r_ovf;

endmodule
